cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Shares the single CPU-side port of the 4-way cache controller between NREQ requesters: instruction fetch, data load/store and the blitter DMA.
- Latches the winning request, holds it stable on the cache port until the cache drops m_bsy, then returns data and an ack to the winner.
- Arbitration is round-robin, with an optional lock for atomic sequences and a busy-timeout error flag.
- Sits between the CPU/DMA masters and the cache, entirely in the cpu_clk domain.

Parameters:
- NREQ, 3, number of requesters; index 0 = ifetch, 1 = data, 2 = DMA.
- TMO_BITS, 16, width of the busy-timeout counter; timeout fires after 2^TMO_BITS-1 busy cycles.

Ports:
- cpu_clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- q_rd  in  NREQ  per-requester read request; level, held until q_ack.
- q_wr  in  NREQ  per-requester write request; level, held until q_ack.
- q_lock  in  NREQ  keep the grant after this transaction completes.
- q_addr  in  NREQ*32  flattened addresses; requester i uses [32i+31:32i].
- q_din  in  NREQ*32  flattened write data.
- q_ctrl  in  NREQ*4  flattened byte masks.
- q_ack  out  NREQ  one-cycle completion pulse to the owning requester.
- q_dout  out  32  read data, broadcast; valid only in the q_ack cycle.
- m_addr  out  32  to cache.
- m_din  out  32  to cache.
- m_ctrl  out  4  to cache.
- m_rd  out  1  to cache.
- m_wr  out  1  to cache.
- m_dout  in  32  from cache.
- m_bsy  in  1  from cache.
- gnt  out  2  index of the current or last owner.
- err_tmo  out  1  sticky busy-timeout flag.

Behaviour:
- Reset values:
  - State IDLE; m_rd = m_wr = 0.
  - m_addr, m_din, m_ctrl = 0.
  - q_ack = 0; gnt = NREQ-1, so requester 0 has first priority.
  - err_tmo = 0; timeout counter = 0; lock = 0.
- Request: requester i is pending when q_rd[i] | q_wr[i]. If both are high, the write wins and the read is ignored for that transaction.
- State IDLE:
  - If any request is pending, pick the first pending index scanning gnt+1, gnt+2, … with wrap modulo NREQ.
  - Register gnt, addr, din, ctrl and op into the m_* outputs; go to ACT.
  - m_rd/m_wr assert on the cycle after the request is seen (1-cycle grant latency).
  - If nothing is pending, stay in IDLE.
- State ACT:
  - m_* held constant.
  - Completion is a cycle where m_bsy = 0 while m_rd|m_wr = 1. In that cycle:
    - q_ack[gnt] = 1 combinationally.
    - q_dout = m_dout for a read; q_dout is don't-care for a write.
    - m_rd/m_wr deassert at the next edge.
  - Go to GAP.
  - lock register <= q_lock[gnt], sampled in the completion cycle.
- State GAP:
  - Exactly one cycle with m_rd = m_wr = 0, so the cache request latch returns to idle.
  - Then:
    - If lock = 1 and the same requester is pending, re-grant it without arbitration (go to ACT next cycle).
    - Otherwise go to IDLE and arbitrate normally.
  - Minimum back-to-back period per transaction: grant + ≥1 ACT + GAP.
- Requester rules:
  - A requester must keep its request high until its q_ack.
  - Any change to a granted requester's inputs is ignored, because the copies are latched.
  - A requester that is not granted sees q_ack[i] = 0 throughout.
- Fairness:
  - No requester waits more than NREQ-1 foreign transactions, unless lock is in use.
  - A lock held by requester i starves the others; that is permitted.
- Timeout:
  - The counter increments every ACT cycle with m_bsy = 1 and clears on entry to ACT.
  - At all-ones, err_tmo <= 1 (sticky until rst).
  - The transaction is not aborted.
- Reset mid-transaction: on the next edge, all state returns to reset values and no ack is issued. The pending requester must re-request, and is then re-arbitrated from requester 0's priority.
- Simultaneous events:
  - A completion cycle and a new pending request: the new request is granted only after GAP.
  - rst asserted in the completion cycle: q_ack is still high combinationally in that cycle, and state resets at the edge.

Test Plan:
- Single read: q_rd[1] = 1, addr 0x0000_1234, cache m_bsy low at ACT cycle 2 with m_dout 0xDEADBEEF → m_rd high for 2 cycles, q_ack = 3'b010 pulse, q_dout = 0xDEADBEEF, then 1 GAP cycle.
- Round-robin: all three requesters reading continuously, each cache access 1 cycle → grant order 0,1,2,0,1,2; every ack separated by the GAP cycle.
- Write priority and masking: q_rd[2] = q_wr[2] = 1, ctrl 4'b0011, din 0x0000_55AA → m_wr = 1, m_rd = 0, m_ctrl = 4'b0011; requester changes q_addr during ACT → m_addr unchanged.
- Lock: requester 1 with q_lock = 1 does 3 writes while requester 0 is pending → gnt stays 1 for all 3; requester 0 is granted immediately after the first unlocked completion.
- Cache miss stall: m_bsy held high 300 cycles with TMO_BITS = 8 → err_tmo rises after cycle 255 and stays high; ack still occurs when m_bsy drops.
- Reset mid-ACT: rst pulsed during a pending miss → next cycle m_rd = 0, gnt = 2, no q_ack; re-requested access completes normally.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the cache controller's single CPU-side port.
// Latches the winner's request, holds it until the cache completes, then acks it.
module cache_port_arbiter #(
  parameter int NREQ     = 3,
  parameter int TMO_BITS = 16
) (
  input  logic                cpu_clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     q_rd,
  input  logic [NREQ-1:0]     q_wr,
  input  logic [NREQ-1:0]     q_lock,
  input  logic [NREQ*32-1:0]  q_addr,
  input  logic [NREQ*32-1:0]  q_din,
  input  logic [NREQ*4-1:0]   q_ctrl,
  output logic [NREQ-1:0]     q_ack,
  output logic [31:0]         q_dout,
  output logic [31:0]         m_addr,
  output logic [31:0]         m_din,
  output logic [3:0]          m_ctrl,
  output logic                m_rd,
  output logic                m_wr,
  input  logic [31:0]         m_dout,
  input  logic                m_bsy,
  output logic [1:0]          gnt,
  output logic                err_tmo
);

  // state | meaning
  // IDLE  | no owner; arbitrate among pending requesters
  // ACT   | request presented to the cache, waiting for m_bsy low
  // GAP   | one idle cycle on the cache port; locked owner may re-enter ACT
  typedef enum logic [1:0] {IDLE, ACT, GAP} state_t;

  localparam logic [TMO_BITS-1:0] TMO_LAST = {{(TMO_BITS-1){1'b1}}, 1'b0};

  state_t               state, state_nxt;
  logic                 lock;
  logic [TMO_BITS-1:0]  tmo_cnt;
  logic [NREQ-1:0]      pend;
  logic [1:0]           win, cand, load_idx;
  logic                 win_vld, load, cmpl;

  assign pend = q_rd | q_wr;
  assign cmpl = (state == ACT) && !m_bsy && (m_rd || m_wr);

  // Round-robin scan starting just after the last owner.
  always_comb begin
    win     = gnt;
    win_vld = 1'b0;
    cand    = gnt;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 2'((int'(gnt) + k) % NREQ);
      if (!win_vld && pend[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_idx  = win;
    case (state)
      IDLE: begin
        if (win_vld) begin
          load      = 1'b1;
          state_nxt = ACT;
        end
      end
      ACT: begin
        if (cmpl) state_nxt = GAP;
      end
      GAP: begin
        if (lock && pend[gnt]) begin
          load      = 1'b1;
          load_idx  = gnt;
          state_nxt = ACT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    q_ack = '0;
    if (cmpl) q_ack[gnt] = 1'b1;
  end

  assign q_dout = (cmpl && m_rd) ? m_dout : 32'h0;

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 2'(NREQ-1);
      m_addr  <= '0;
      m_din   <= '0;
      m_ctrl  <= '0;
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
      lock    <= 1'b0;
      tmo_cnt <= '0;
      err_tmo <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        gnt     <= load_idx;
        m_addr  <= q_addr[32*load_idx +: 32];
        m_din   <= q_din[32*load_idx +: 32];
        m_ctrl  <= q_ctrl[4*load_idx +: 4];
        // Write wins when a requester raises both strobes.
        m_wr    <= q_wr[load_idx];
        m_rd    <= q_rd[load_idx] & ~q_wr[load_idx];
        tmo_cnt <= '0;
      end else if (cmpl) begin
        m_rd <= 1'b0;
        m_wr <= 1'b0;
        lock <= q_lock[gnt];
      end else if (state == ACT && m_bsy) begin
        if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
        if (tmo_cnt == TMO_LAST) err_tmo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: a cache model drives m_bsy/m_dout and
// a scoreboard monitor checks every q_ack against the expected transaction order.
module tb_cache_port_arbiter;

  logic        cpu_clk = 1'b0;
  logic        rst;
  logic [2:0]  q_rd, q_wr, q_lock, q_ack;
  logic [95:0] q_addr, q_din;
  logic [11:0] q_ctrl;
  logic [31:0] q_dout, m_addr, m_din, m_dout;
  logic [3:0]  m_ctrl;
  logic        m_rd, m_wr, m_bsy, err_tmo;
  logic [1:0]  gnt;

  cache_port_arbiter #(.NREQ(3), .TMO_BITS(8)) dut (
    .cpu_clk(cpu_clk), .rst(rst),
    .q_rd(q_rd), .q_wr(q_wr), .q_lock(q_lock),
    .q_addr(q_addr), .q_din(q_din), .q_ctrl(q_ctrl),
    .q_ack(q_ack), .q_dout(q_dout),
    .m_addr(m_addr), .m_din(m_din), .m_ctrl(m_ctrl), .m_rd(m_rd), .m_wr(m_wr),
    .m_dout(m_dout), .m_bsy(m_bsy),
    .gnt(gnt), .err_tmo(err_tmo)
  );

  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  ctrl;
    logic [31:0] dout;
  } txn_t;

  txn_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  int          lat = 0;
  bit          fixed_mode = 1'b0;
  logic [31:0] fixed_dout = 32'h0;

  function automatic logic [31:0] cache_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  // Cache model: busy for 'lat' cycles after the request appears.
  initial begin
    int  cnt;
    bit  active;
    cnt = 0; active = 1'b0;
    m_bsy = 1'b0; m_dout = 32'h0;
    forever begin
      @(posedge cpu_clk); #1;
      if (m_rd || m_wr) begin
        if (!active) begin active = 1'b1; cnt = 0; end
        else cnt++;
        m_bsy  = (cnt < lat);
        m_dout = fixed_mode ? fixed_dout : cache_data(m_addr);
      end else begin
        active = 1'b0;
        m_bsy  = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge cpu_clk) begin
    if (q_ack !== 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {29'h0, q_ack}, 32'h0);
      end else begin
        txn_t e;
        e = sb.pop_front();
        chk("ack_onehot", {29'h0, q_ack}, 32'(3'b001 << e.idx));
        chk("ack_gnt", {30'h0, gnt}, 32'(e.idx));
        chk("ack_m_addr", m_addr, e.addr);
        chk("ack_m_wr", {31'h0, m_wr}, {31'h0, e.wr});
        chk("ack_m_rd", {31'h0, m_rd}, {31'h0, ~e.wr});
        if (e.wr) begin
          chk("ack_m_din", m_din, e.din);
          chk("ack_m_ctrl", {28'h0, m_ctrl}, {28'h0, e.ctrl});
        end else begin
          chk("ack_q_dout", q_dout, e.dout);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge cpu_clk); #1; end
  endtask

  task automatic req(input int i, input bit rd, input bit wr, input bit lk,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] c);
    q_rd[i] = rd; q_wr[i] = wr; q_lock[i] = lk;
    q_addr[32*i +: 32] = a; q_din[32*i +: 32] = d; q_ctrl[4*i +: 4] = c;
  endtask

  task automatic drop(input int i);
    q_rd[i] = 1'b0; q_wr[i] = 1'b0; q_lock[i] = 1'b0;
  endtask

  task automatic expect_txn(input int i, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] c);
    txn_t t;
    t.idx = i; t.wr = wr; t.addr = a; t.din = d; t.ctrl = c;
    t.dout = fixed_mode ? fixed_dout : cache_data(a);
    sb.push_back(t);
  endtask

  // Returns at #1 after the edge ending the ack cycle (i.e. inside GAP).
  task automatic wait_ack(input int i, input int budget, output int at);
    at = -1;
    for (int b = 0; b < budget; b++) begin
      @(negedge cpu_clk);
      if (q_ack[i]) begin at = cyc; break; end
    end
    chk("ack_seen", {31'h0, at >= 0}, 32'h1);
    @(posedge cpu_clk); #1;
  endtask

  task automatic wait_any(input int budget, output int idx, output int at);
    at = -1; idx = 0;
    for (int b = 0; b < budget; b++) begin
      @(negedge cpu_clk);
      if (q_ack !== 3'b000) begin
        at = cyc;
        for (int j = 0; j < 3; j++) if (q_ack[j]) idx = j;
        break;
      end
    end
    chk("any_ack_seen", {31'h0, at >= 0}, 32'h1);
    @(posedge cpu_clk); #1;
  endtask

  task automatic wait_mrd(input int budget);
    bit seen;
    seen = 1'b0;
    for (int b = 0; b < budget; b++) begin
      @(negedge cpu_clk);
      if (m_rd) begin seen = 1'b1; break; end
    end
    chk("m_rd_seen", {31'h0, seen}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int at, prev, idx;
    int nxt[3];

    rst = 1'b1;
    q_rd = '0; q_wr = '0; q_lock = '0; q_addr = '0; q_din = '0; q_ctrl = '0;
    tick(2);
    @(negedge cpu_clk);
    chk("rst_m_rd", {31'h0, m_rd}, 32'h0);
    chk("rst_m_wr", {31'h0, m_wr}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_gnt", {30'h0, gnt}, 32'h2);
    chk("rst_err", {31'h0, err_tmo}, 32'h0);
    chk("rst_ack", {29'h0, q_ack}, 32'h0);
    @(posedge cpu_clk); #1;
    rst = 1'b0;
    tick(1);

    // Single read with one busy cycle.
    lat = 1; fixed_mode = 1'b1; fixed_dout = 32'hDEAD_BEEF;
    req(1, 1, 0, 0, 32'h0000_1234, 32'h0, 4'hF);
    expect_txn(1, 0, 32'h0000_1234, 32'h0, 4'hF);
    @(negedge cpu_clk);
    chk("lat_m_rd_c0", {31'h0, m_rd}, 32'h0);
    @(negedge cpu_clk);
    chk("rd_m_rd_c1", {31'h0, m_rd}, 32'h1);
    chk("rd_ack_c1", {29'h0, q_ack}, 32'h0);
    @(negedge cpu_clk);
    chk("rd_m_rd_c2", {31'h0, m_rd}, 32'h1);
    chk("rd_ack_c2", {29'h0, q_ack}, 32'h2);
    @(posedge cpu_clk); #1;
    drop(1);
    @(negedge cpu_clk);
    chk("gap_m_rd", {31'h0, m_rd}, 32'h0);
    chk("gap_ack", {29'h0, q_ack}, 32'h0);
    @(negedge cpu_clk);
    chk("idle_m_rd", {31'h0, m_rd}, 32'h0);
    tick(1);

    // Round-robin, all three reading continuously, zero-wait cache.
    lat = 0; fixed_mode = 1'b0;
    for (int n = 0; n < 2; n++) begin
      expect_txn(2, 0, 32'h1000_0000 + 32'(2 << 4) + 32'(n << 8), 32'h0, 4'hF);
      expect_txn(0, 0, 32'h1000_0000 + 32'(0 << 4) + 32'(n << 8), 32'h0, 4'hF);
      expect_txn(1, 0, 32'h1000_0000 + 32'(1 << 4) + 32'(n << 8), 32'h0, 4'hF);
    end
    for (int i = 0; i < 3; i++) begin
      nxt[i] = 0;
      req(i, 1, 0, 0, 32'h1000_0000 + 32'(i << 4), 32'h0, 4'hF);
    end
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      wait_any(20, idx, at);
      if (prev >= 0) chk("rr_spacing", 32'(at - prev), 32'd3);
      prev = at;
      nxt[idx]++;
      if (nxt[idx] < 2) req(idx, 1, 0, 0, 32'h1000_0000 + 32'(idx << 4) + 32'(nxt[idx] << 8), 32'h0, 4'hF);
      else drop(idx);
    end
    tick(2);

    // Write wins over read; latched address ignores later changes.
    lat = 3;
    req(2, 1, 1, 0, 32'h2000_0040, 32'h0000_55AA, 4'b0011);
    expect_txn(2, 1, 32'h2000_0040, 32'h0000_55AA, 4'b0011);
    tick(1);
    @(negedge cpu_clk);
    chk("wp_m_wr", {31'h0, m_wr}, 32'h1);
    chk("wp_m_rd", {31'h0, m_rd}, 32'h0);
    chk("wp_m_ctrl", {28'h0, m_ctrl}, 32'h3);
    @(posedge cpu_clk); #1;
    q_addr[64 +: 32] = 32'hFFFF_FFFF;
    q_din[64 +: 32]  = 32'h1111_1111;
    @(negedge cpu_clk);
    chk("wp_addr_held", m_addr, 32'h2000_0040);
    wait_ack(2, 10, at);
    drop(2);
    tick(2);

    // Lock: requester 1 keeps the port for three writes while 0 waits.
    lat = 1;
    req(1, 0, 1, 1, 32'h3000_0000, 32'h1, 4'hF);
    expect_txn(1, 1, 32'h3000_0000, 32'h1, 4'hF);
    expect_txn(1, 1, 32'h3000_0004, 32'h2, 4'hF);
    expect_txn(1, 1, 32'h3000_0008, 32'h3, 4'hF);
    expect_txn(0, 0, 32'h4000_0000, 32'h0, 4'hF);
    tick(1);
    req(0, 1, 0, 0, 32'h4000_0000, 32'h0, 4'hF);
    wait_ack(1, 10, at);
    req(1, 0, 1, 1, 32'h3000_0004, 32'h2, 4'hF);
    wait_ack(1, 10, at);
    req(1, 0, 1, 0, 32'h3000_0008, 32'h3, 4'hF);
    wait_ack(1, 10, prev);
    drop(1);
    wait_ack(0, 10, at);
    chk("lock_release_lat", 32'(at - prev), 32'd4);
    drop(0);
    tick(2);

    // Long miss: timeout flag after 255 busy cycles, transaction still completes.
    lat = 300;
    req(0, 1, 0, 0, 32'h5000_0000, 32'h0, 4'hF);
    expect_txn(0, 0, 32'h5000_0000, 32'h0, 4'hF);
    wait_mrd(10);
    repeat (254) @(negedge cpu_clk);
    chk("tmo_before", {31'h0, err_tmo}, 32'h0);
    @(negedge cpu_clk);
    chk("tmo_rise", {31'h0, err_tmo}, 32'h1);
    wait_ack(0, 60, at);
    drop(0);
    tick(3);
    chk("tmo_sticky", {31'h0, err_tmo}, 32'h1);

    // Reset in the middle of a miss, then re-request.
    lat = 50;
    req(1, 1, 0, 0, 32'h6000_0000, 32'h0, 4'hF);
    wait_mrd(10);
    tick(5);
    rst = 1'b1;
    @(negedge cpu_clk);
    chk("prerst_ack", {29'h0, q_ack}, 32'h0);
    @(posedge cpu_clk); #1;
    @(negedge cpu_clk);
    chk("mid_rst_m_rd", {31'h0, m_rd}, 32'h0);
    chk("mid_rst_gnt", {30'h0, gnt}, 32'h2);
    chk("mid_rst_err", {31'h0, err_tmo}, 32'h0);
    chk("mid_rst_ack", {29'h0, q_ack}, 32'h0);
    @(posedge cpu_clk); #1;
    rst = 1'b0;
    lat = 1;
    req(1, 1, 0, 0, 32'h6000_0010, 32'h0, 4'hF);
    expect_txn(1, 0, 32'h6000_0010, 32'h0, 4'hF);
    wait_ack(1, 10, at);
    drop(1);
    tick(3);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
